match_ctrl: RTL
===============

# match_ctrl

Match sequencer for the soccer-heads game. It owns the match state machine and decides when the ball and player datapaths may run. It holds the ball at its start position through kickoff and goal celebration, and detects goals from the ball position. It also keeps both scores and the match clock, and declares the winner. It sits between the keyboard/keycode path and the ball and player movers, and drives their hold and enable inputs.

## Interface
- START_KEY, 8'h28, keycode that starts a match (Enter)
- GOAL_L_X, 10'd40, x of left goal line; ball past it scores for P2
- GOAL_R_X, 10'd600, x of right goal line; ball past it scores for P1
- GOAL_MOUTH_Y, 10'd330, ball centre y must be strictly greater than this to count as a goal (below the crossbar)
- WIN_SCORE, 4'd5, first player to this score wins
- KICKOFF_FRAMES, 10'd120, length of KICKOFF state in frames
- GOAL_FRAMES, 10'd180, length of GOAL celebration in frames
- FRAMES_PER_SEC, 7'd60, frame ticks per match-clock second
- MATCH_SECONDS, 7'd90, match length
- frame_clk  in  1  frame clock; all state advances on its rising edge
- Reset  in  1  asynchronous, active-high reset
- keycode  in  8  current keyboard code, 0 when no key is pressed
- BallX, BallY, BallS  in  10 each  ball centre position and half-size
- ball_hold  out  1  high: the ball mover must hold its Reset-equivalent start position
- AllowInput  out  1  high: the player movers accept keyboard and AI motion
- score_p1, score_p2  out  4 each  goals scored
- time_left  out  7  seconds remaining
- state  out  3  IDLE=0, KICKOFF=1, PLAY=2, GOAL=3, OVER=4
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw; valid in OVER
- goal_pulse  out  1  one-frame pulse on the edge that enters GOAL

## Operation
- Start edge: keycode==START_KEY this frame and the registered previous keycode!=START_KEY. A held key never re-triggers.
- IDLE: ball_hold=1, AllowInput=0. A start edge moves to KICKOFF; scores clear to 0, time_left loads MATCH_SECONDS, the sub-second counter clears.
- KICKOFF: ball_hold=1, AllowInput=1. The frame counter runs 0..KICKOFF_FRAMES-1, then the state moves to PLAY with the counter cleared.
- PLAY: ball_hold=0, AllowInput=1.
  - Sub-second counter counts 0..FRAMES_PER_SEC-1. On wrap, time_left decrements, saturating at 0.
  - Left goal: BallX <= GOAL_L_X + BallS and BallY > GOAL_MOUTH_Y. This adds 1 to score_p2. The addition form avoids unsigned underflow near x=0.
  - Right goal: BallX + BallS >= GOAL_R_X and BallY > GOAL_MOUTH_Y. This adds 1 to score_p1.
  - Both goal conditions true together: only the left goal counts.
  - On a goal: go to GOAL, pulse goal_pulse, clear the frame counter. A score saturates at 15.
  - With no goal, time_left==0 goes to OVER.
- GOAL: ball_hold=1, AllowInput=0, match clock frozen. After GOAL_FRAMES frames:
  - go to OVER if either score >= WIN_SCORE or time_left==0;
  - otherwise go to KICKOFF.
- OVER: ball_hold=1, AllowInput=0.
  - winner is set on entry: 1 if score_p1>score_p2, 2 if less, 3 if equal.
  - A start edge behaves as in IDLE (new match, winner cleared to 0).
- Illegal state codes (5-7) return to IDLE on the next edge.

## Timing
- All outputs are registered; every decision uses inputs sampled on the same frame_clk edge.
- Reset values: state=IDLE, ball_hold=1, AllowInput=0, score_p1=score_p2=0, time_left=MATCH_SECONDS, winner=0, goal_pulse=0, all counters 0, previous keycode=0.
- Reset mid-match returns to these values immediately (asynchronous). Play resumes only after a new start edge.
- Start edge sampled on edge N gives state=KICKOFF after edge N.
- KICKOFF lasts exactly KICKOFF_FRAMES edges; GOAL lasts exactly GOAL_FRAMES edges.
- Goal condition true at edge N gives the score increment, goal_pulse=1, state=GOAL and ball_hold=1, all after edge N. goal_pulse returns to 0 after edge N+1.
- Goal on the same edge that time_left would decrement to 0: the goal counts and the decrement still applies. GOAL then exits to OVER.
- time_left reaches 0 after MATCH_SECONDS*FRAMES_PER_SEC PLAY frames, not counting KICKOFF or GOAL frames.

## Test plan
- Reset, then keycode 0x28 for 3 frames -> one KICKOFF entry. PLAY follows after 120 frames with ball_hold=0 and time_left=90.
- PLAY with BallX=30, BallS=16, BallY=400 -> score_p2=1 and a one-frame goal_pulse; state=GOAL for 180 frames, then KICKOFF.
- BallX=620, BallY=300 (above the crossbar) -> no goal. BallY=340 -> score_p1 increments.
- Set MATCH_SECONDS=2 and hold the ball mid-field -> time_left 2,1,0 at 60-frame steps. OVER with winner=3.
- Drive five P1 goals -> OVER after the fifth GOAL, winner=1. A start edge clears scores and enters KICKOFF.
- Assert Reset during GOAL -> all outputs return to reset values immediately. keycode held at 0x28 through release of Reset does not start a match; a release then press does.

Source files
------------

// File: rtl/match_ctrl.sv
// Match sequencer for soccer-heads: owns the IDLE/KICKOFF/PLAY/GOAL/OVER flow,
// the scores, the match clock, and the hold/enable lines to the movers.
module match_ctrl #(
  parameter logic [7:0] START_KEY      = 8'h28,
  parameter logic [9:0] GOAL_L_X       = 10'd40,
  parameter logic [9:0] GOAL_R_X       = 10'd600,
  parameter logic [9:0] GOAL_MOUTH_Y   = 10'd330,
  parameter logic [3:0] WIN_SCORE      = 4'd5,
  parameter logic [9:0] KICKOFF_FRAMES = 10'd120,
  parameter logic [9:0] GOAL_FRAMES    = 10'd180,
  parameter logic [6:0] FRAMES_PER_SEC = 7'd60,
  parameter logic [6:0] MATCH_SECONDS  = 7'd90
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic       ball_hold,
  output logic       AllowInput,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [6:0] time_left,
  output logic [2:0] state,
  output logic [1:0] winner,
  output logic       goal_pulse
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KICKOFF = 3'd1,
    S_PLAY    = 3'd2,
    S_GOAL    = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] prev_key_q;
  logic       armed_q, armed_d;
  logic [9:0] frame_cnt_q, frame_cnt_d;
  logic [6:0] sub_cnt_q, sub_cnt_d;
  logic [6:0] time_left_d;
  logic [3:0] score_p1_d, score_p2_d;
  logic [1:0] winner_d;
  logic       goal_pulse_d, ball_hold_d, allow_input_d;
  logic       start_edge, goal_left, goal_right;
  logic [10:0] left_line, right_edge;

  function automatic logic [1:0] decide_winner(input logic [3:0] p1, input logic [3:0] p2);
    if (p1 > p2)      decide_winner = 2'd1;
    else if (p1 < p2) decide_winner = 2'd2;
    else              decide_winner = 2'd3;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    sat_inc = (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  // A key held across reset release must be let go before it can start a match.
  assign start_edge = armed_q && (keycode == START_KEY) && (prev_key_q != START_KEY);
  assign armed_d    = armed_q || (keycode != START_KEY);

  // 11-bit sums so BallX+BallS cannot wrap near the right edge.
  assign left_line  = {1'b0, GOAL_L_X} + {1'b0, BallS};
  assign right_edge = {1'b0, BallX} + {1'b0, BallS};
  assign goal_left  = ({1'b0, BallX} <= left_line) && (BallY > GOAL_MOUTH_Y);
  assign goal_right = (right_edge >= {1'b0, GOAL_R_X}) && (BallY > GOAL_MOUTH_Y);

  assign state = state_q;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    sub_cnt_d    = sub_cnt_q;
    time_left_d  = time_left;
    score_p1_d   = score_p1;
    score_p2_d   = score_p2;
    winner_d     = winner;
    goal_pulse_d = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d     = S_KICKOFF;
          frame_cnt_d = 10'd0;
          sub_cnt_d   = 7'd0;
          time_left_d = MATCH_SECONDS;
          score_p1_d  = 4'd0;
          score_p2_d  = 4'd0;
          winner_d    = 2'd0;
        end
      end
      S_KICKOFF: begin
        if (frame_cnt_q == KICKOFF_FRAMES - 10'd1) begin
          state_d     = S_PLAY;
          frame_cnt_d = 10'd0;
        end else begin
          frame_cnt_d = frame_cnt_q + 10'd1;
        end
      end
      S_PLAY: begin
        // The clock keeps running on a goal edge; GOAL then sees the new value.
        if (sub_cnt_q == FRAMES_PER_SEC - 7'd1) begin
          sub_cnt_d = 7'd0;
          if (time_left != 7'd0) time_left_d = time_left - 7'd1;
        end else begin
          sub_cnt_d = sub_cnt_q + 7'd1;
        end
        if (goal_left || goal_right) begin
          if (goal_left) score_p2_d = sat_inc(score_p2);
          else           score_p1_d = sat_inc(score_p1);
          state_d      = S_GOAL;
          goal_pulse_d = 1'b1;
          frame_cnt_d  = 10'd0;
        end else if (time_left == 7'd0) begin
          state_d  = S_OVER;
          winner_d = decide_winner(score_p1, score_p2);
        end
      end
      S_GOAL: begin
        if (frame_cnt_q == GOAL_FRAMES - 10'd1) begin
          frame_cnt_d = 10'd0;
          if ((score_p1 >= WIN_SCORE) || (score_p2 >= WIN_SCORE) || (time_left == 7'd0)) begin
            state_d  = S_OVER;
            winner_d = decide_winner(score_p1, score_p2);
          end else begin
            state_d = S_KICKOFF;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + 10'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ball_hold_d   = (state_d != S_PLAY);
    allow_input_d = (state_d == S_KICKOFF) || (state_d == S_PLAY);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      prev_key_q  <= 8'd0;
      armed_q     <= 1'b0;
      frame_cnt_q <= 10'd0;
      sub_cnt_q   <= 7'd0;
      time_left   <= MATCH_SECONDS;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      winner      <= 2'd0;
      goal_pulse  <= 1'b0;
      ball_hold   <= 1'b1;
      AllowInput  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_key_q  <= keycode;
      armed_q     <= armed_d;
      frame_cnt_q <= frame_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      time_left   <= time_left_d;
      score_p1    <= score_p1_d;
      score_p2    <= score_p2_d;
      winner      <= winner_d;
      goal_pulse  <= goal_pulse_d;
      ball_hold   <= ball_hold_d;
      AllowInput  <= allow_input_d;
    end
  end

endmodule
